// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte requesters / uart_tx pair and uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_data_in;
  logic                 uart_transmit;
  logic                 uart_busy;
  logic [GW-1:0]        grant_id;
  logic                 active;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, req_lock, uart_busy,
    input  req_ready, uart_data_in, uart_transmit, grant_id, active, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_lock, uart_busy,
    output req_ready, uart_data_in, uart_transmit, grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with per-requester lock and a timeout on the UART's busy acknowledge.

module uart_tx_arbiter_chk #(
  parameter int NUM_REQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               uart_busy,
  input logic               uart_transmit,
  input logic               timeout_err
);
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_ready_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (req_ready != '0) |-> !uart_busy);

  a_transmit_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    uart_transmit |=> !uart_transmit);

  a_timeout_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    timeout_err |=> !timeout_err);
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [GW-1:0]       grant_r;
  logic [7:0]          data_r;
  logic                transmit_r;
  logic                active_r;
  logic                timeout_r;
  logic [CW-1:0]       cnt_r;

  logic [CW-1:0]       cnt_nxt_s;
  logic                transmit_nxt_s;
  logic                active_nxt_s;
  logic                timeout_nxt_s;
  logic [GW-1:0]       sel_idx_s;
  logic                sel_found_s;
  logic [GW-1:0]       cand_s;
  logic [7:0]          sel_byte_s;
  logic                accept_s;
  logic [NUM_REQ-1:0]  ready_s;

  // Winner selection: a locked, still-valid owner keeps the grant, else first valid after it.
  always_comb begin
    sel_idx_s   = grant_r;
    sel_found_s = 1'b0;
    cand_s      = grant_r;
    if (bus.req_lock[grant_r] && bus.req_valid[grant_r]) begin
      sel_found_s = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand_s = GW'((int'(grant_r) + k) % NUM_REQ);
        if (!sel_found_s && bus.req_valid[cand_s]) begin
          sel_found_s = 1'b1;
          sel_idx_s   = cand_s;
        end else begin
          sel_found_s = sel_found_s;
        end
      end
    end
  end

  // Handshake decode and byte mux; accept is held off during reset so no ready leaks out.
  always_comb begin
    accept_s   = rst_n && (state_r == IDLE) && !bus.uart_busy && sel_found_s;
    ready_s    = '0;
    sel_byte_s = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = accept_s && (sel_idx_s == GW'(i));
      sel_byte_s = sel_byte_s | (bus.req_data[i*8 +: 8] & {8{sel_idx_s == GW'(i)}});
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = {CW{1'b0}};
    transmit_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s    = ISSUE;
          transmit_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // Timeout wins over a late busy rise: the counter already hit the limit.
        if (cnt_r == CNT_MAX) begin
          state_nxt_s = IDLE;
        end else if (bus.uart_busy) begin
          state_nxt_s = WAIT_DONE;
          cnt_nxt_s   = cnt_r;
        end else begin
          state_nxt_s = WAIT_BUSY;
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_busy) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    active_nxt_s  = (state_nxt_s != IDLE);
    timeout_nxt_s = (state_nxt_s == WAIT_BUSY) && (cnt_nxt_s == CNT_MAX);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      grant_r    <= GRANT_RST;
      data_r     <= 8'h00;
      transmit_r <= 1'b0;
      active_r   <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      transmit_r <= transmit_nxt_s;
      active_r   <= active_nxt_s;
      timeout_r  <= timeout_nxt_s;
      if (accept_s) begin
        grant_r <= sel_idx_s;
        data_r  <= sel_byte_s;
      end
    end
  end

  assign bus.req_ready     = ready_s;
  assign bus.uart_data_in  = data_r;
  assign bus.uart_transmit = transmit_r;
  assign bus.grant_id      = grant_r;
  assign bus.active        = active_r;
  assign bus.timeout_err   = timeout_r;

  uart_tx_arbiter_chk #(.NUM_REQ(NUM_REQ)) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_ready     (ready_s),
    .uart_busy     (bus.uart_busy),
    .uart_transmit (transmit_r),
    .timeout_err   (timeout_r)
  );
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues feed the bus, expected
// (id, byte) pairs are queued with the stimulus and matched on each transmit pulse.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int FRAME_LEN    = 10;

  typedef struct { int id; logic [7:0] data; logic lock; } item_t;
  typedef struct { int id; logic [7:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int busy_mode = 0;   // 0: UART model, 1: forced low, 2: forced high
  int frame_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;
  item_t item_q[$];
  exp_t  exp_q[$];
  logic [NUM_REQ-1:0] rdy_lat = '0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.uart_busy = (busy_mode == 2) ? 1'b1 :
                         (busy_mode == 1) ? 1'b0 : (frame_cnt != 0);

  // Minimal uart_tx stand-in: busy for FRAME_LEN cycles after each transmit pulse.
  always @(posedge clk) begin
    if (bus.uart_transmit) frame_cnt <= FRAME_LEN;
    else if (frame_cnt != 0) frame_cnt <= frame_cnt - 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_item(input int id, input logic [7:0] data, input logic lock);
    item_t it;
    it.id = id; it.data = data; it.lock = lock;
    item_q.push_back(it);
  endtask

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id = id; e.data = data;
    exp_q.push_back(e);
  endtask

  // Requester driver and scoreboard, all on the falling edge.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ*8-1:0] d;
    logic [NUM_REQ-1:0]   l;
    exp_t e;
    if (bus.uart_transmit) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_tx", 32'(bus.uart_data_in), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_data", 32'(bus.uart_data_in), 32'(e.data));
        check_eq("sb_grant", 32'(bus.grant_id), 32'(e.id));
        check_eq("sb_ready_prev", 32'(rdy_lat), 32'(1) << e.id);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy_lat[i]) begin
        for (int k = 0; k < item_q.size(); k++) begin
          if (item_q[k].id == i) begin
            item_q.delete(k);
            break;
          end
        end
      end
    end
    v = '0; d = '0; l = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < item_q.size(); k++) begin
        if (!v[i] && item_q[k].id == i) begin
          v[i] = 1'b1;
          d[i*8 +: 8] = item_q[k].data;
          l[i] = item_q[k].lock;
        end
      end
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_lock  = l;
    #1;
    rdy_lat = bus.req_ready;
    if (bus.uart_transmit) check_eq("ready_one_cycle", 32'(rdy_lat), 32'd0);
    if ((rdy_lat & (rdy_lat - 1'b1)) != '0) check_eq("ready_onehot", 32'(rdy_lat), 32'd0);
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((item_q.size() != 0 || exp_q.size() != 0 || bus.active ||
            bus.uart_busy || bus.uart_transmit) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drained"}, 32'(n < 400), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.uart_transmit && n < 200);
    check_eq({tag, "_tx_seen"}, 32'(bus.uart_transmit), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},    32'(bus.req_ready),     32'd0);
    check_eq({tag, "_data"},     32'(bus.uart_data_in),  32'd0);
    check_eq({tag, "_transmit"}, 32'(bus.uart_transmit), 32'd0);
    check_eq({tag, "_grant"},    32'(bus.grant_id),      32'(NUM_REQ - 1));
    check_eq({tag, "_active"},   32'(bus.active),        32'd0);
    check_eq({tag, "_timeout"},  32'(bus.timeout_err),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // single byte from requester 2
    push_item(2, 8'h55, 1'b0);
    push_exp(2, 8'h55);
    wait_tx("single");
    check_eq("single_grant", 32'(bus.grant_id), 32'd2);
    check_eq("single_active", 32'(bus.active), 32'd1);
    wait_idle("single");
    check_eq("single_data_hold", 32'(bus.uart_data_in), 32'h55);

    // contention from a fresh reset: 0, 1, 3 in that order, then 3 alone
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check_eq("rst2_data", 32'(bus.uart_data_in), 32'd0);
    push_item(0, 8'hA3, 1'b0); push_item(1, 8'h5A, 1'b0); push_item(3, 8'h0F, 1'b0);
    push_exp(0, 8'hA3); push_exp(1, 8'h5A); push_exp(3, 8'h0F);
    wait_idle("contend");
    check_eq("contend_grant", 32'(bus.grant_id), 32'd3);
    push_item(3, 8'h3C, 1'b0);
    push_exp(3, 8'h3C);
    wait_idle("contend_again");

    // locked burst from requester 1 while requester 0 waits
    push_item(1, 8'h11, 1'b1);
    push_exp(1, 8'h11);
    wait_tx("lock_first");
    push_item(1, 8'h22, 1'b1); push_item(1, 8'h33, 1'b1); push_item(0, 8'h44, 1'b0);
    push_exp(1, 8'h22); push_exp(1, 8'h33); push_exp(0, 8'h44);
    wait_idle("lock");

    // locked burst then rotation resumes at 2, 3, 0
    push_item(1, 8'h12, 1'b1); push_item(1, 8'h13, 1'b1);
    push_item(0, 8'hC0, 1'b0); push_item(2, 8'hC2, 1'b0); push_item(3, 8'hC3, 1'b0);
    push_exp(1, 8'h12); push_exp(1, 8'h13);
    push_exp(2, 8'hC2); push_exp(3, 8'hC3); push_exp(0, 8'hC0);
    wait_idle("lock_rot");

    // busy never rises: timeout, drop, next request served
    busy_mode = 1;
    push_item(2, 8'h77, 1'b0); push_item(3, 8'h78, 1'b0);
    push_exp(2, 8'h77); push_exp(3, 8'h78);
    wait_tx("timeout");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.timeout_err && n < 40);
    check_eq("timeout_latency", 32'(n), 32'd17);
    @(negedge clk);
    check_eq("timeout_pulse_width", 32'(bus.timeout_err), 32'd0);
    check_eq("timeout_idle", 32'(bus.active), 32'd0);
    #2;
    check_eq("timeout_next_ready", 32'(bus.req_ready), 32'b1000);
    wait_idle("timeout");
    busy_mode = 0;
    wait_idle("timeout_release");

    // external busy holds off all grants
    busy_mode = 2;
    push_item(0, 8'h90, 1'b0); push_item(1, 8'h91, 1'b0);
    push_exp(0, 8'h90); push_exp(1, 8'h91);
    repeat (8) begin
      @(negedge clk);
      #2;
      check_eq("extbusy_no_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    busy_mode = 0;
    #2;
    check_eq("extbusy_grant", 32'(bus.req_ready), 32'b0001);
    wait_idle("extbusy");

    // reset during WAIT_DONE
    push_item(2, 8'hAA, 1'b0);
    push_exp(2, 8'hAA);
    wait_tx("midrst");
    push_item(3, 8'hB3, 1'b0); push_item(0, 8'hB0, 1'b0);
    push_exp(0, 8'hB0); push_exp(3, 8'hB3);
    repeat (2) @(negedge clk);
    check_eq("midrst_in_frame", 32'({bus.active, bus.uart_busy}), 32'b11);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    wait_idle("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. Each requester offers a byte with a valid/ready handshake. The arbiter captures the granted byte, pulses `transmit` to the UART, and then tracks the UART's `busy` flag until the frame completes. A per-requester lock keeps multi-byte messages contiguous, and a busy-timeout recovers if the UART never acknowledges a transmit pulse.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `BUSY_TIMEOUT`, 16, cycles allowed after the `transmit` pulse for `uart_busy` to rise (≥2).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `req_valid`  in  NUM_REQ  requester i has a byte pending.
- `req_data`  in  NUM_REQ*8  byte of requester i in bits [8i+7:8i].
- `req_lock`  in  NUM_REQ  requester i requests to keep the grant after its current byte.
- `req_ready`  out  NUM_REQ  one-hot; byte of requester i is accepted this cycle.
- `uart_data_in`  out  8  byte to `uart_tx.data_in`.
- `uart_transmit`  out  1  one-cycle start pulse to `uart_tx.transmit`.
- `uart_busy`  in  1  `uart_tx.busy`.
- `grant_id`  out  $clog2(NUM_REQ)  index of the last accepted requester.
- `active`  out  1  arbiter is not in IDLE.
- `timeout_err`  out  1  one-cycle pulse when a busy timeout occurs.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on accept.
  - ISSUE → WAIT_BUSY unconditionally.
  - WAIT_BUSY → WAIT_DONE when `uart_busy`=1.
  - WAIT_BUSY → IDLE when the counter reaches `BUSY_TIMEOUT`.
  - WAIT_DONE → IDLE when `uart_busy`=0.
- Accept happens only in IDLE with `uart_busy`=0 and at least one `req_valid`. `req_ready` is combinational and asserted for exactly the selected requester.
- Selection:
  - Lock override: if `req_lock[grant_id]` and `req_valid[grant_id]` are both 1, `grant_id` is selected again.
  - Otherwise round-robin: search starts at `grant_id`+1 (mod NUM_REQ) and the first valid index wins.
- Lock is evaluated only at accept time. A locked requester that drops `req_valid` loses the lock, and rotation resumes from it.
- On accept:
  - the selected byte is registered into `uart_data_in`;
  - `grant_id` updates to the selected index.
- `uart_data_in` holds stable until the next accept.
- ISSUE drives `uart_transmit`=1 for exactly one cycle.
- WAIT_BUSY counter:
  - clears on entry;
  - increments each cycle with `uart_busy`=0;
  - on reaching `BUSY_TIMEOUT`, `timeout_err` pulses and the FSM returns to IDLE with no retry. The byte is dropped.
- `req_valid` must hold until `req_ready`. The arbiter ignores any `req_data` change before acceptance.
- Requesters never see a second `req_ready` before the current frame ends.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=0;
  - `uart_data_in`=0x00;
  - `uart_transmit`=0;
  - `grant_id`=NUM_REQ-1, so requester 0 has first priority;
  - `active`=0;
  - `timeout_err`=0;
  - timeout counter 0.
- Reset mid-frame aborts the arbiter immediately; the transmitter's state is not affected.
- Accept at edge T. `uart_transmit`=1 in cycle T+1. WAIT_BUSY begins at T+2.
- `uart_busy` may already be 1 at T+2. In that case WAIT_DONE is entered at T+3.
- Frame end: `uart_busy` falls while in WAIT_DONE at edge E. IDLE is reached at E, and the next accept is possible in cycle E+1 if `uart_busy`=0.
- Timeout: `timeout_err` is high in the cycle in which the counter equals `BUSY_TIMEOUT`. The FSM is in IDLE the following cycle.
- `uart_busy`=1 while in IDLE (external or leftover): no grant until it falls.
- Simultaneous valids: exactly one grant per frame, with the order set by the rotation rules above.
- `active`=1 in ISSUE, WAIT_BUSY and WAIT_DONE.

## Test plan
- Single byte: `req_valid[2]`=1 with 0x55 after reset. Required:
  - `req_ready`=0b0100 for one cycle;
  - `uart_transmit` pulse the following cycle;
  - `uart_data_in`=0x55;
  - `tx` serializes 0x55 LSB-first;
  - `grant_id`=2.
- Contention: requesters 0, 1 and 3 valid with 0xA3, 0x5A and 0x0F. Required:
  - frames go out in order 0xA3, 0x5A, 0x0F;
  - requester 3 valid again afterwards is granted next, before any other.
- Lock: requester 1 sends 0x11, 0x22, 0x33 with `req_lock[1]`=1 while requester 0 holds 0x44 pending. Required:
  - order 0x11, 0x22, 0x33, then 0x44;
  - after lock drops, rotation resumes at requester 2, then 3, then 0.
- Timeout with `BUSY_TIMEOUT`=16 and `uart_busy` tied 0. Required:
  - `timeout_err` pulses exactly 16 cycles after WAIT_BUSY entry;
  - FSM returns to IDLE;
  - the next pending request is granted.
- External busy: `uart_busy` forced 1 with requests pending. Required:
  - no `req_ready` while high;
  - grant occurs the cycle after `uart_busy` falls.
- Reset mid-frame: `rst_n`=0 for 1 cycle during WAIT_DONE. Required:
  - all outputs return to reset values at the next edge;
  - requester 0 has priority afterwards.
